instr_mem_loader: RTL and testbench

- Byte-stream program loader: the write side of the CPU's instruction memory.
- Accepts a framed byte stream from an upstream byte source (UART receiver or testbench) over valid/ready.
- Packs bytes little-endian into 32-bit words and drives the instruction-memory write port.
- Holds the CPU core in reset until a complete, valid program has been written.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/instr_mem_loader_word_packer.sv | 35 +++
 rtl/instr_mem_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// Little-endian 8-to-32 packer: each byte enters at the top of the word, so the
// first of four bytes ends up in bits [7:0].
module word_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  cnt_r;
    logic [31:0] word_r;

    // Shift register and byte-within-word counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r  <= 2'd0;
            word_r <= 32'd0;
        end else if (clr_i) begin
            cnt_r  <= 2'd0;
            word_r <= 32'd0;
        end else if (load_i) begin
            cnt_r  <= cnt_r + 2'd1;
            word_r <= {byte_i, word_r[31:8]};
        end
    end

    assign word_o      = word_r;
    assign word_full_o = load_i && (cnt_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Framed byte-stream program loader driving the instruction-memory write port.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int LEN_W = 8 * LEN_BYTES;
    localparam logic [LEN_W:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    loader_state_t    state_r;
    loader_state_t    state_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_full_s;
    logic [LEN_W-1:0] word_idx_r;
    logic             byte_ready_r;
    logic             mem_we_r;
    logic             core_rst_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             accept_s;
    logic             start_s;
    logic             pk_load_s;
    logic             pk_full_s;
    logic [31:0]      pk_word_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_r;
`endif

    assign accept_s   = byte_valid_i && byte_ready_r;
    assign start_s    = start_i && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR));
    assign pk_load_s  = accept_s && (state_r == DATA);
    assign len_full_s = {byte_i, len_r[7:0]};

    word_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (start_s),
        .load_i      (pk_load_s),
        .byte_i      (byte_i),
        .word_o      (pk_word_s),
        .word_full_o (pk_full_s)
    );

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE, ERROR: begin
                if (start_i) state_s = LEN_LO;
                else         state_s = state_r;
            end
            LEN_LO: begin
                if (accept_s) state_s = LEN_HI;
                else          state_s = LEN_LO;
            end
            LEN_HI: begin
                if (!accept_s) begin
                    state_s = LEN_HI;
                end else if (len_full_s == {LEN_W{1'b0}}) begin
`ifdef LOADER_CHECKSUM_EN
                    state_s = CHECK;
`else
                    state_s = DONE;
`endif
                end else if ({1'b0, len_full_s} > MAX_WORDS) begin
                    state_s = ERROR;
                end else begin
                    state_s = DATA;
                end
            end
            DATA: begin
                if (pk_full_s) state_s = WRITE;
                else           state_s = DATA;
            end
            WRITE: begin
                if ((word_idx_r + LEN_W'(1'b1)) == len_r) begin
`ifdef LOADER_CHECKSUM_EN
                    state_s = CHECK;
`else
                    state_s = DONE;
`endif
                end else begin
                    state_s = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (!accept_s)              state_s = CHECK;
                else if (byte_i == csum_r)  state_s = DONE;
                else                        state_s = ERROR;
            end
`endif
            default: state_s = IDLE;
        endcase
    end

    // State register; outputs are decoded from the next state so they are flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            core_rst_r   <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            byte_ready_r <= (state_s == LEN_LO) || (state_s == LEN_HI) ||
                            (state_s == DATA)   || (state_s == CHECK);
            mem_we_r     <= (state_s == WRITE);
            core_rst_r   <= (state_s != DONE);
            busy_r       <= (state_s == LEN_LO) || (state_s == LEN_HI) || (state_s == DATA) ||
                            (state_s == WRITE)  || (state_s == CHECK);
            done_r       <= (state_s == DONE);
            err_r        <= (state_s == ERROR);
        end
    end

    // Length latch and word index (the index doubles as the write address).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_r      <= {LEN_W{1'b0}};
            word_idx_r <= {LEN_W{1'b0}};
        end else begin
            if (start_s)                               len_r <= {LEN_W{1'b0}};
            else if (accept_s && (state_r == LEN_LO))  len_r <= {len_r[LEN_W-1:8], byte_i};
            else if (accept_s && (state_r == LEN_HI))  len_r <= len_full_s;

            if (start_s)                 word_idx_r <= {LEN_W{1'b0}};
            else if (state_r == WRITE)   word_idx_r <= word_idx_r + LEN_W'(1'b1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every data byte of the frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          csum_r <= 8'h00;
        else if (start_s)   csum_r <= 8'h00;
        else if (pk_load_s) csum_r <= csum_update(csum_r, byte_i);
    end
`endif

    assign byte_ready_o = byte_ready_r;
    assign mem_we_o     = mem_we_r;
    assign mem_addr_o   = {{(32 - LEN_W - 2){1'b0}}, word_idx_r, 2'b00};
    assign mem_wdata_o  = pk_word_s;
    assign core_rst_o   = core_rst_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader with a frame-level reference model.
module tb_instr_mem_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] words_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          ready_in_write = 0;

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_rst_o   (core_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory-side monitor.
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_wdata_o);
            if (byte_ready_o) ready_in_write++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_stall);
        int guard;
        int stall;
        stall = int'($urandom_range(max_stall, 0));
        for (int s = 0; s < stall; s++) begin
            byte_i = 8'($urandom());
            @(negedge clk_i);
        end
        byte_i = b;
        byte_valid_i = 1'b1;
        guard = 0;
        while (!byte_ready_o && guard < 64) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 64) begin
            n_cmp++; n_bad++;
            $display("FAIL byte_handshake: ready=%b after %0d cycles, required 1", byte_ready_o, guard);
        end
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    // Drives one complete session for length n over words_q and checks the outcome.
    task automatic load_frame(input int n, input int max_stall, input bit bad_sum, input bit glitch_start);
        logic [7:0]  sum;
        logic [31:0] w;
        bit          exp_err;
        int          exp_writes;
        int          exp_lat;
        int          lat;
        logic        we_at_end;

        frame_q.delete();
        sum = 8'h00;
        frame_q.push_back(8'(n % 256));
        frame_q.push_back(8'((n / 256) % 256));
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < n; i++) begin
                w = words_q[i];
                for (int k = 0; k < 4; k++) begin
                    frame_q.push_back(8'((w >> (8 * k)) % 256));
                    sum = sum ^ 8'((w >> (8 * k)) % 256);
                end
            end
            if (CSUM) frame_q.push_back(bad_sum ? (sum ^ 8'h5A) : sum);
        end
        exp_err    = (n > MAX_WORDS) || (CSUM && bad_sum);
        exp_writes = (n > MAX_WORDS) ? 0 : n;
        exp_lat    = (n > 0 && n <= MAX_WORDS && !CSUM) ? 1 : 0;

        wr_addr_q.delete();
        wr_data_q.delete();
        ready_in_write = 0;

        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n_cmp++;
        if ({core_rst_o, busy_o, byte_ready_o, done_o, err_o} !== 5'b11100) begin
            n_bad++;
            $display("FAIL start_entry: rst/busy/ready/done/err=%b required 11100",
                     {core_rst_o, busy_o, byte_ready_o, done_o, err_o});
        end

        foreach (frame_q[i]) begin
            if (glitch_start && i == 3) begin
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
            end
            send_byte(frame_q[i], max_stall);
        end

        we_at_end = mem_we_o;
        lat = 0;
        while (!(done_o || err_o) && lat < 16) begin
            @(negedge clk_i);
            lat++;
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL end_latency: n=%0d got %0d cycles, required %0d", n, lat, exp_lat);
        end
        if (exp_lat == 1) begin
            n_cmp++;
            if (we_at_end !== 1'b1) begin
                n_bad++;
                $display("FAIL last_write_strobe: mem_we_o=%b required 1", we_at_end);
            end
        end
        n_cmp++;
        if ({done_o, err_o, core_rst_o, busy_o} !== {!exp_err, exp_err, exp_err, 1'b0}) begin
            n_bad++;
            $display("FAIL final_status: n=%0d done/err/core_rst/busy=%b required %b", n,
                     {done_o, err_o, core_rst_o, busy_o}, {!exp_err, exp_err, exp_err, 1'b0});
        end
        n_cmp++;
        if (wr_addr_q.size() != exp_writes) begin
            n_bad++;
            $display("FAIL write_count: n=%0d got %0d writes, required %0d", n, wr_addr_q.size(), exp_writes);
        end
        for (int i = 0; i < exp_writes && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== words_q[i]) begin
                n_bad++;
                $display("FAIL write_%0d: addr=%h data=%h required addr=%h data=%h",
                         i, wr_addr_q[i], wr_data_q[i], 32'(i * 4), words_q[i]);
            end
        end
        n_cmp++;
        if (ready_in_write != 0) begin
            n_bad++;
            $display("FAIL ready_during_write: %0d cycles with ready high, required 0", ready_in_write);
        end
    endtask

    task automatic test_reset();
        int ready_seen;
        rst_i = 1'b1;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_o, busy_o, done_o, err_o} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: ready=%b we=%b addr=%h wdata=%h core_rst=%b busy=%b done=%b err=%b",
                     byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_o, busy_o, done_o, err_o);
        end
        rst_i = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        ready_seen = 0;
        byte_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            byte_i = 8'($urandom());
            @(negedge clk_i);
            if (byte_ready_o) ready_seen++;
        end
        byte_valid_i = 1'b0;
        n_cmp++;
        if (ready_seen != 0 || wr_addr_q.size() != 0 || core_rst_o !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_bytes: ready_cycles=%0d writes=%0d core_rst=%b busy=%b required 0 0 1 0",
                     ready_seen, wr_addr_q.size(), core_rst_o, busy_o);
        end
    endtask

    task automatic test_normal_load();
        words_q.delete();
        words_q.push_back(32'h0000_0013);
        words_q.push_back(32'hDEAD_BEEF);
        load_frame(2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        load_frame(2, 7, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            words_q.delete();
            for (int i = 0; i < 8; i++) words_q.push_back($urandom());
            load_frame(int'($urandom_range(8, 1)), 7, 1'b0, 1'b0);
        end
    endtask

    task automatic test_length_edges();
        words_q.delete();
        load_frame(0, 2, 1'b0, 1'b0);
        load_frame(16'h0401, 2, 1'b0, 1'b0);
        for (int i = 0; i < MAX_WORDS; i++) words_q.push_back($urandom());
        load_frame(MAX_WORDS, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        words_q.delete();
        words_q.push_back($urandom());
        words_q.push_back($urandom());
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'((words_q[i / 4] >> (8 * (i % 4))) % 256), 1);
        #2;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_o, busy_o, done_o, err_o} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_values: ready=%b we=%b addr=%h wdata=%h core_rst=%b busy=%b done=%b err=%b",
                     byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_o, busy_o, done_o, err_o);
        end
        n_cmp++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== words_q[0]) begin
            n_bad++;
            $display("FAIL abort_partial: writes=%0d required 1 at 0 with %h", wr_addr_q.size(), words_q[0]);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        words_q.delete();
        for (int i = 0; i < 3; i++) words_q.push_back($urandom());
        load_frame(3, 3, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            words_q.delete();
            for (int i = 0; i < 5; i++) words_q.push_back($urandom());
            load_frame(5, 0, 1'b0, 1'b0);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        words_q.delete();
        words_q.push_back(32'h4433_2211);
        load_frame(1, 0, 1'b1, 1'b0);
        load_frame(1, 0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_normal_load();
        test_stall();
        test_length_edges();
        test_abort();
        test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
